fetch_flags_unit: RTL

FETCH_FLAGS_UNIT -- requirements
Module: fetch_flags_unit

---
 rtl/fetch_flags_unit.sv | 71 +++++++
 1 files changed

// File: rtl/fetch_flags_unit.sv
// fetch_flags_unit: program counter, instruction register, N/Z flags, halt latch and retired-instruction counter.
module fetch_flags_unit #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCwrite,
  input  logic             PC_sel,
  input  logic             IRload,
  input  logic             FlagWrite,
  input  logic             R1Sel,
  input  logic             Stop,
  input  logic [7:0]       mem_rdata,
  input  logic [7:0]       alu_result,
  output logic [7:0]       pc,
  output logic [7:0]       ir,
  output logic [3:0]       instr,
  output logic             N,
  output logic             Z,
  output logic [7:0]       imm3,
  output logic [7:0]       imm4,
  output logic [7:0]       imm5,
  output logic [1:0]       r1_addr,
  output logic [1:0]       r2_addr,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  logic [7:0]       pc_d, pc_q, ir_d, ir_q;
  logic             n_d, n_q, z_d, z_q, halted_d, halted_q, wen;
  logic [CNT_W-1:0] retired_d, retired_q;
  // Stop blocks every write in its own cycle, not only from the next one.
  always_comb begin
    wen       = !halted_q && !Stop;
    pc_d      = (wen && PCwrite) ? (PC_sel ? alu_result : pc_q + 8'd1) : pc_q;
    ir_d      = (wen && IRload) ? mem_rdata : ir_q;
    n_d       = (wen && FlagWrite) ? alu_result[7] : n_q;
    z_d       = (wen && FlagWrite) ? (alu_result == 8'd0) : z_q;
    halted_d  = halted_q || Stop;
    retired_d = (wen && IRload && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      ir_q      <= 8'h00;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      n_q       <= n_d;
      z_q       <= z_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign instr   = ir_q[3:0];
  assign N       = n_q;
  assign Z       = z_q;
  assign halted  = halted_q;
  assign retired = retired_q;
  assign imm4    = {{4{ir_q[7]}}, ir_q[7:4]};
  assign imm5    = {3'b000, ir_q[7:3]};
  assign imm3    = {5'b00000, ir_q[5:3]};
  assign r1_addr = R1Sel ? 2'b01 : ir_q[7:6];
  assign r2_addr = ir_q[5:4];
endmodule
